mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single 4096 x 36 unified memory (combinational read, write on rising clock edge) between the instruction-fetch unit (port 0) and the load/store unit (port 1). It registers the winning request, drives the memory for exactly one cycle, captures read data and returns a one-cycle acknowledge to the winner. Round-robin arbitration prevents either port from starving. It sits between the processor core and the memory instance.

## Interface
- ADDR_W, 12, address width (4096 words)
- DATA_W, 36, word width
- PROT_BASE, 2048, lowest write-protected address (program region); used only with MEM_ARB_WPROT_EN
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_req, p1_req  in  1 each  access request, held high until ack
- p0_we, p1_we  in  1 each  1 = write, 0 = read
- p0_addr, p1_addr  in  ADDR_W each  word address
- p0_wdata, p1_wdata  in  DATA_W each  write data
- p0_ack, p1_ack  out  1 each  one-cycle completion pulse
- p0_rdata, p1_rdata  out  DATA_W each  read data, valid while ack high, held afterwards
- p0_err, p1_err  out  1 each  protection-violation pulse, coincident with ack
- mem_we  out  1  to memory write_enable
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory write_data
- mem_rdata  in  DATA_W  from memory read_data

## Operation
- FSM states IDLE, ACCESS. Reset: IDLE, all outputs 0, last_grant = 1.
- IDLE: eligible port = req high and its own ack not high this cycle. None eligible -> stay IDLE. Otherwise winner registered at the edge (id, we, addr, wdata) -> ACCESS.
- Arbitration: one eligible -> it wins. Both eligible -> the port != last_grant wins; last_grant updated to winner. First contention after reset goes to port 0.
- ACCESS: mem_addr/mem_wdata = registered values; mem_we = registered we (gated by protection, see Configuration). At the closing edge: winner's rdata <= mem_rdata (reads and writes both update rdata; for writes it is the pre-write word), winner's ack <= 1, state -> IDLE.
- IDLE drives mem_we = 0; mem_addr/mem_wdata hold last values.
- Requester must keep req, we, addr, wdata stable from assertion until ack; changes before ack are undefined behaviour.
- Port whose ack is high is masked from arbitration that cycle, so a held req is never double-served; it may re-request from the next cycle.
- Reset mid-ACCESS: state -> IDLE and mem_we -> 0 immediately (asynchronous); pending write is not performed, no ack issued.

## Timing
- Latency: req sampled at edge E -> memory access during cycle E..E+1 -> ack high in cycle after E+1 (2 cycles).
- Throughput: one access per 2 cycles; with both ports constantly requesting, grants alternate 0,1,0,1.
- ack, err, rdata are registered; no combinational path from port inputs to port outputs. mem_we/mem_addr/mem_wdata are registered (mem_we additionally ANDed with state == ACCESS).

## Configuration
- MEM_ARB_WPROT_EN defined: a write with addr >= PROT_BASE keeps mem_we = 0 throughout ACCESS, memory unchanged; ack still pulses with err = 1 in the same cycle; rdata updated as for a read.
- Undefined: all writes pass; p0_err, p1_err tied 0; PROT_BASE unused.

## Structure
- Package mem_arb_pkg: ADDR_W/DATA_W defaults, PROT_BASE default, FSM state enum.
- Sub-module mem_arb_rr: 2-input round-robin picker (eligible vector, last_grant in; grant one-hot out), purely combinational, last_grant register stays in the top.

## Test plan
- Reset with both req high: all outputs 0 during reset; first grant after release goes to port 0, p0_ack 2 cycles after first sampled req.
- p1 write addr 5 data 36'h123456789, then p0 read addr 5 -> p0_rdata = 36'h123456789, p1_rdata after write = old word.
- Both ports request continuously for 8 grants -> ack order 0,1,0,1,0,1,0,1; no cycle with both acks high.
- MEM_ARB_WPROT_EN: p1 write addr 2048 data 36'hFFFFFFFFF -> p1_ack and p1_err together, mem_we never high, subsequent read of 2048 returns original; without macro write succeeds, err stays 0.
- rst_n low during ACCESS of a write to addr 10 -> mem_we drops immediately, no ack, addr 10 unchanged.
- Port 0 holds req through its ack cycle -> no grant in ack cycle, new grant next cycle, second ack 2 cycles later.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared defaults and FSM state type for the two-port unified-memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 36;
    localparam int DEF_PROT_BASE = 2048;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker: with both eligible, the port that did not win last time wins.
module mem_arb_rr (
    input  logic [1:0] elig_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    assign grant_o = (&elig_i) ? (last_grant_i ? 2'b01 : 2'b10) : elig_i;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 4096x36 memory between instruction fetch (port 0) and load/store (port 1).
// Optional write protection of the program region is enabled with MEM_ARB_WPROT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef MEM_ARB_WPROT_EN
    ,
    parameter int PROT_BASE = DEF_PROT_BASE
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_ack,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p0_err,
    output logic              p1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q;
    logic              last_grant_q;
    logic              id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              blk_q;

    logic [1:0]        elig;
    logic [1:0]        grant;
    logic              win_we_d;
    logic [ADDR_W-1:0] win_addr_d;
    logic [DATA_W-1:0] win_wdata_d;
    logic              wr_blk_d;

    // A port is masked while its ack is high so a still-held req is not served twice.
    assign elig = {p1_req & ~ack1_q, p0_req & ~ack0_q};

    mem_arb_rr u_rr (
        .elig_i       (elig),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        win_we_d    = p0_we;
        win_addr_d  = p0_addr;
        win_wdata_d = p0_wdata;
        if (grant[1]) begin
            win_we_d    = p1_we;
            win_addr_d  = p1_addr;
            win_wdata_d = p1_wdata;
        end
    end

`ifdef MEM_ARB_WPROT_EN
    localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROT_BASE);

    logic err0_q, err1_q;

    assign wr_blk_d = win_we_d && (win_addr_d >= PROT_ADDR);
    assign p0_err   = err0_q;
    assign p1_err   = err1_q;
`else
    assign wr_blk_d = 1'b0;
    assign p0_err   = 1'b0;
    assign p1_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            blk_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef MEM_ARB_WPROT_EN
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
`endif
        end else begin
            // NOTE: state is assigned with <= so every register samples pre-edge values.
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
`ifdef MEM_ARB_WPROT_EN
            err0_q <= 1'b0;
            err1_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        id_q         <= grant[1];
                        we_q         <= win_we_d;
                        addr_q       <= win_addr_d;
                        wdata_q      <= win_wdata_d;
                        blk_q        <= wr_blk_d;
                        last_grant_q <= grant[1];
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // rdata captures the pre-write word for writes as well.
                    if (id_q) begin
                        rdata1_q <= mem_rdata;
                        ack1_q   <= 1'b1;
`ifdef MEM_ARB_WPROT_EN
                        err1_q   <= blk_q;
`endif
                    end else begin
                        rdata0_q <= mem_rdata;
                        ack0_q   <= 1'b1;
`ifdef MEM_ARB_WPROT_EN
                        err0_q   <= blk_q;
`endif
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we    = (state_q == ACCESS) & we_q & ~blk_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p0_ack    = ack0_q;
    assign p1_ack    = ack1_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 4096x36 memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic        p0_we = 1'b0, p1_we = 1'b0;
    logic [11:0] p0_addr = '0, p1_addr = '0;
    logic [35:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [35:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [35:0] mem_wdata, mem_rdata;

    typedef struct {
        int          port;
        logic [35:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   mem_we_cnt = 0;

`ifdef MEM_ARB_WPROT_EN
    localparam logic PROT = 1'b1;
`else
    localparam logic PROT = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_err(p0_err), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [35:0] init_word(input logic [11:0] a);
        return {24'hC0FFEE, a};
    endfunction

    // NOTE: the memory array is never reset; unwritten words read as init_word(addr).
    logic [35:0] mem [4096];
    bit          written [4096];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    assign mem_rdata = written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every acknowledge.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) mem_we_cnt <= mem_we_cnt + 1;
        if (rst_n && (p0_ack || p1_ack)) begin
            check("single_ack", 64'(p0_ack & p1_ack), 64'(0));
            check("sb_pending", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("ack_port", 64'(p1_ack ? 1 : 0), 64'(e.port));
                check("rdata", 64'(p1_ack ? p1_rdata : p0_rdata), 64'(e.rdata));
                check("err", 64'(p1_ack ? p1_err : p0_err), 64'(e.err));
            end
        end
    end

    task automatic push(input int port, input logic [35:0] rdata, input logic err);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic set_port(input int port, input logic req, input logic we,
                            input logic [11:0] addr, input logic [35:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic wait_ack(input int port);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_ack : p1_ack) found = 1'b1;
        end
        if (!found) check("ack_timeout", 64'(0), 64'(1));
    endtask

    task automatic drive(input int port, input logic we, input logic [11:0] addr,
                         input logic [35:0] wdata, input int n);
        set_port(port, 1'b1, we, addr, wdata);
        for (int k = 0; k < n; k++) wait_ack(port);
        set_port(port, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int cnt0;

        // Reset with both ports requesting.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        set_port(0, 1'b1, 1'b0, 12'd1, '0);
        set_port(1, 1'b1, 1'b0, 12'd2, '0);
        repeat (3) @(negedge clk);
        check("rst_p0_ack", 64'(p0_ack), 64'(0));
        check("rst_p1_ack", 64'(p1_ack), 64'(0));
        check("rst_p0_err", 64'(p0_err), 64'(0));
        check("rst_p1_err", 64'(p1_err), 64'(0));
        check("rst_p0_rdata", 64'(p0_rdata), 64'(0));
        check("rst_p1_rdata", 64'(p1_rdata), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        push(0, init_word(12'd1), 1'b0);
        push(1, init_word(12'd2), 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("lat_p0_early", 64'(p0_ack), 64'(0));
        @(negedge clk);
        check("lat_p0_ack", 64'(p0_ack), 64'(1));
        set_port(0, 1'b0, 1'b0, '0, '0);
        wait_ack(1);
        set_port(1, 1'b0, 1'b0, '0, '0);

        // Write through port 1, read back through port 0.
        push(1, init_word(12'd5), 1'b0);
        drive(1, 1'b1, 12'd5, 36'h123456789, 1);
        push(0, 36'h123456789, 1'b0);
        drive(0, 1'b0, 12'd5, '0, 1);

        // Write into the program region.
        cnt0 = mem_we_cnt;
        push(1, init_word(12'd2048), PROT);
        drive(1, 1'b1, 12'd2048, 36'hFFFFFFFFF, 1);
        @(negedge clk);
        check("wprot_mem_we_cycles", 64'(mem_we_cnt - cnt0), PROT ? 64'(0) : 64'(1));
        push(0, PROT ? init_word(12'd2048) : 36'hFFFFFFFFF, 1'b0);
        drive(0, 1'b0, 12'd2048, '0, 1);

        // Port 0 holds req through its ack: one idle cycle, then a fresh grant.
        push(0, init_word(12'd30), 1'b0);
        push(0, init_word(12'd30), 1'b0);
        set_port(0, 1'b1, 1'b0, 12'd30, '0);
        wait_ack(0);
        @(negedge clk);
        check("hold_gap1", 64'(p0_ack), 64'(0));
        @(negedge clk);
        check("hold_gap2", 64'(p0_ack), 64'(0));
        @(negedge clk);
        check("hold_ack2", 64'(p0_ack), 64'(1));
        set_port(0, 1'b0, 1'b0, '0, '0);

        // Reset in the middle of a write access.
        @(negedge clk);
        set_port(1, 1'b1, 1'b1, 12'd10, 36'h0DEADBEEF);
        @(posedge clk);
        #1 check("rst_mid_we_on", 64'(mem_we), 64'(1));
        #2 rst_n = 1'b0;
        #1 check("rst_mid_we_drop", 64'(mem_we), 64'(0));
        set_port(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_mid_no_ack", 64'(p1_ack), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_no_ack2", 64'(p1_ack), 64'(0));

        // Both ports request continuously: grants alternate starting with port 0.
        for (int i = 0; i < 4; i++) begin
            push(0, init_word(12'd20), 1'b0);
            push(1, init_word(12'd21), 1'b0);
        end
        fork
            drive(0, 1'b0, 12'd20, '0, 4);
            drive(1, 1'b0, 12'd21, '0, 4);
        join
        @(negedge clk);

        // The aborted write must have left address 10 untouched.
        push(0, init_word(12'd10), 1'b0);
        drive(0, 1'b0, 12'd10, '0, 1);
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
